aes_inv_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 52 +++++
 rtl/aes_inv_round.sv | 34 +++
 rtl/inv_s_box.sv | 14 +
 rtl/aes_inv_iter.sv | 101 ++++++++++
 tb/tb_aes_inv_iter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES inverse-cipher datapath.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  localparam int unsigned AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } inv_fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round; FINAL=1 omits InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
#(
  parameter bit FINAL = 1'b0
) (
  input  aes_state_t state_i,
  input  aes_state_t round_key_i,
  output aes_state_t state_o
);
  logic [7:0] sb_in [16];
  logic [7:0] sb_out[16];
  logic [7:0] ak    [16];

  for (genvar i = 0; i < 16; i++) begin : g_byte
    // Byte i sits at column i/4, row i%4; InvShiftRows rotates row r right by r.
    localparam int Src = (((i / 4) + 4 - (i % 4)) % 4) * 4 + (i % 4);
    assign sb_in[i] = state_i[127-8*Src -: 8];
    inv_s_box u_sbox (
      .data_i(sb_in[i]),
      .data_o(sb_out[i])
    );
    assign ak[i] = sb_out[i] ^ round_key_i[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    if (FINAL) begin : g_final
      assign state_o[127-32*c -: 32] = {ak[4*c], ak[4*c+1], ak[4*c+2], ak[4*c+3]};
    end else begin : g_mix
      assign state_o[127-32*c -: 32] = inv_mix_col({ak[4*c], ak[4*c+1], ak[4*c+2], ak[4*c+3]});
    end
  end

endmodule

// File: rtl/inv_s_box.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module inv_s_box
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  logic [7:0] pre;

  assign pre = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^
               {data_i[1:0], data_i[7:2]} ^ 8'h05;
  assign data_o = gf_inv(pre);

endmodule

// File: rtl/aes_inv_iter.sv
// Iterative AES-128 inverse cipher, one inverse round per enabled clock.
// Optional AES_INV_KEY_LATCH_EN captures the whole round-key schedule at accept.
module aes_inv_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [127:0]       ciphertext_i,
  input  logic [10:0][127:0] round_key_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [127:0]       plaintext_o
);
  if (NR != AES_NR) begin : g_nr_check
    $error("aes_inv_iter supports only NR=10");
  end

  inv_fsm_t   fsm_q;
  logic [3:0] cnt_q;
  aes_state_t state_q;
  aes_state_t rk;
  aes_state_t mid_out;
  aes_state_t final_out;

`ifdef AES_INV_KEY_LATCH_EN
  logic [10:0][127:0] key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else if (en && fsm_q == IDLE && valid_i) begin
      key_q <= round_key_i;
    end
  end

  assign rk = key_q[cnt_q];
`else
  assign rk = round_key_i[cnt_q];
`endif

  aes_inv_round #(
    .FINAL(1'b0)
  ) u_round_mid (
    .state_i    (state_q),
    .round_key_i(rk),
    .state_o    (mid_out)
  );

  aes_inv_round #(
    .FINAL(1'b1)
  ) u_round_final (
    .state_i    (state_q),
    .round_key_i(rk),
    .state_o    (final_out)
  );

  assign ready_o     = en && (fsm_q == IDLE);
  assign plaintext_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      valid_o <= 1'b0;
    end else if (en) begin
      unique case (fsm_q)
        IDLE: begin
          if (valid_i) begin
            state_q <= ciphertext_i ^ round_key_i[10];
            cnt_q   <= 4'd9;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (cnt_q == 4'd0) begin
            state_q <= final_out;
            valid_o <= 1'b1;
            fsm_q   <= DONE;
          end else begin
            state_q <= mid_out;
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            fsm_q   <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_iter.sv
// Self-checking bench for aes_inv_iter against a behavioural AES-128 encryption model.
module tb_aes_inv_iter;
  logic               clk = 1'b0;
  logic               rst, en, valid_i, ready_o, valid_o, ready_i;
  logic [127:0]       ciphertext_i, plaintext_o;
  logic [10:0][127:0] round_key_i;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  logic [7:0]  sbox[256];

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;

  aes_inv_iter dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ciphertext_i(ciphertext_i),
    .round_key_i (round_key_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .plaintext_o (plaintext_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Carry-less product followed by reduction modulo 0x11B.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [10:0][127:0] expand(input logic [127:0] key);
    logic [31:0]        w[44];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [10:0][127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [10:0][127:0] rk);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      for (int i = 0; i < 16; i++)
        s[127-8*i -: 8] = t[127-8*((((i / 4) + (i % 4)) % 4) * 4 + (i % 4)) -: 8];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03),
                               m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02)};
        end
      end
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one block, waits for the first valid_o cycle and returns there (no transfer yet).
  task automatic run_block(input logic [127:0] ct, input logic [10:0][127:0] rk,
                           input int stall_after, input bit corrupt,
                           output logic [127:0] pt, output int lat, output bit timeout,
                           output int busy_ready, output int unsigned t_acc);
    int n;
    ciphertext_i = ct;
    round_key_i  = rk;
    valid_i      = 1'b1;
    pt = '0; lat = 0; timeout = 1'b0; busy_ready = 0; n = 0;
    while (!ready_o && n < 50) begin
      step();
      n++;
    end
    t_acc = cyc;
    if (!ready_o) begin
      timeout = 1'b1;
      valid_i = 1'b0;
      return;
    end
    step();
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin
      if (corrupt && n == 0) round_key_i = ~rk;
      if (n == stall_after) begin
        en = 1'b0;
        valid_i = 1'b1;
        ciphertext_i = ~ct;
        repeat (3) begin
          if (ready_o) busy_ready++;
          step();
        end
        en = 1'b1;
      end
      if (ready_o) busy_ready++;
      step();
      n++;
    end
    valid_i = 1'b0;
    timeout = !valid_o;
    lat = int'(cyc - t_acc);
    pt = plaintext_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    ciphertext_i = '0; round_key_i = '0;
    step(); step();
    rst = 1'b0;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (plaintext_o !== 128'h0) begin failures++; $display("FAIL reset_pt got=%h exp=0", plaintext_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    en = 1'b0; #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL en0_ready got=%b exp=0", ready_o); end
    en = 1'b1;
  endtask

  task automatic test_fips_b();
    logic [127:0] pt; int lat, busy; bit to; int unsigned ta;
    ready_i = 1'b1;
    run_block(CtB, expand(KeyB), -1, 1'b0, pt, lat, to, busy, ta);
    checks++; if (to) begin failures++; $display("FAIL b_timeout got=timeout exp=valid"); end
    checks++; if (lat != 11) begin failures++; $display("FAIL b_latency got=%0d exp=11", lat); end
    checks++; if (pt !== PtB) begin failures++; $display("FAIL b_pt got=%h exp=%h", pt, PtB); end
    checks++; if (busy != 0) begin failures++; $display("FAIL b_busy_ready got=%0d exp=0", busy); end
    step();
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL b_after_xfer got=v%b r%b exp=v0 r1", valid_o, ready_o);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt; int lat, busy; bit to; int unsigned ta;
    ready_i = 1'b0;
    run_block(CtC, expand(KeyC), -1, 1'b0, pt, lat, to, busy, ta);
    checks++; if (to || pt !== PtC) begin failures++; $display("FAIL c_pt got=%h exp=%h", pt, PtC); end
    repeat (5) begin
      step();
      checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL c_hold_valid got=%b exp=1", valid_o); end
      checks++; if (plaintext_o !== PtC) begin failures++; $display("FAIL c_hold_pt got=%h exp=%h", plaintext_o, PtC); end
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL c_hold_ready got=%b exp=0", ready_o); end
    end
    en = 1'b0; ready_i = 1'b1;
    step();
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL c_en0_hold got=%b exp=1", valid_o); end
    en = 1'b1;
    step();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL c_xfer got=%b exp=0", valid_o); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt; int lat, busy, seen; bit to; int unsigned ta;
    ready_i = 1'b1;
    ciphertext_i = CtB; round_key_i = expand(KeyB); valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ready_o); end
    seen = 0;
    repeat (15) begin
      step();
      if (valid_o) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rmid_no_output got=%0d exp=0", seen); end
    run_block(CtB, expand(KeyB), -1, 1'b0, pt, lat, to, busy, ta);
    checks++; if (to || pt !== PtB) begin failures++; $display("FAIL rmid_after got=%h exp=%h", pt, PtB); end
    step();
  endtask

  task automatic test_enable_stall();
    logic [127:0] pt; int lat, busy, seen; bit to; int unsigned ta;
    ready_i = 1'b1;
    run_block(CtB, expand(KeyB), 3, 1'b0, pt, lat, to, busy, ta);
    checks++; if (to || lat != 14) begin failures++; $display("FAIL stall_latency got=%0d exp=14", lat); end
    checks++; if (pt !== PtB) begin failures++; $display("FAIL stall_pt got=%h exp=%h", pt, PtB); end
    checks++; if (busy != 0) begin failures++; $display("FAIL stall_busy_ready got=%0d exp=0", busy); end
    seen = 0;
    repeat (14) begin
      step();
      if (valid_o) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL stall_busy_accept got=%0d exp=0", seen); end
  endtask

  task automatic test_key_latch();
    logic [127:0] pt; int lat, busy; bit to; int unsigned ta;
    ready_i = 1'b1;
    run_block(CtB, expand(KeyB), -1, 1'b1, pt, lat, to, busy, ta);
    checks++; if (to) begin failures++; $display("FAIL klatch_timeout got=timeout exp=valid"); end
`ifdef AES_INV_KEY_LATCH_EN
    checks++; if (pt !== PtB) begin failures++; $display("FAIL klatch_pt got=%h exp=%h", pt, PtB); end
`else
    checks++; if (pt === PtB) begin failures++; $display("FAIL klatch_neg got=%h exp!=%h", pt, PtB); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0]       exp_q[$];
    logic [127:0]       key, pt_in, got, exp;
    logic [10:0][127:0] rk;
    int                 lat, busy;
    bit                 to;
    int unsigned        ta, prev;
    ready_i = 1'b1;
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      pt_in = {$urandom, $urandom, $urandom, $urandom};
      rk    = expand(key);
      exp_q.push_back(pt_in);
      run_block(encrypt(pt_in, rk), rk, -1, 1'b0, got, lat, to, busy, ta);
      exp = exp_q.pop_front();
      checks++; if (to || got !== exp) begin
        failures++; $display("FAIL b2b_pt[%0d] got=%h exp=%h", i, got, exp);
        if (to) break;
      end
      if (i > 0) begin
        checks++; if (ta - prev != 12) begin
          failures++; $display("FAIL b2b_throughput[%0d] got=%0d exp=12", i, ta - prev);
        end
      end
      prev = ta;
      step();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    ciphertext_i = '0; round_key_i = '0;
    build_sbox();
    @(negedge clk);
    test_reset();
    test_fips_b();
    test_backpressure();
    test_reset_mid();
    test_enable_stall();
    test_key_latch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
